// File: rtl/control_dma.sv
// control_dma: two-channel word-copy DMA engine (READ -> LOAD -> XFER -> WRITE per word).
// Optional macro CONTROL_DMA_ROUND_ROBIN_EN enables round-robin arbitration; default is fixed channel-0 priority.
`default_nettype none

module control_dma #(
  parameter int AW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_0,
  input  logic          req_1,
  input  logic [AW-1:0] src_0,
  input  logic [AW-1:0] src_1,
  input  logic [AW-1:0] dst_0,
  input  logic [AW-1:0] dst_1,
  input  logic [LW-1:0] len_0,
  input  logic [LW-1:0] len_1,
  output logic          gnt_0,
  output logic          gnt_1,
  output logic          done_0,
  output logic          done_1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_ack,
  output logic          Estado_in,
  output logic          Estado_out,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    XFER  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] src_w;
  logic [AW-1:0] dst_w;
  logic [LW-1:0] cnt;
  logic          ch;

  logic          pick;
  logic [AW-1:0] sel_src;
  logic [AW-1:0] sel_dst;
  logic [LW-1:0] sel_len;

`ifdef CONTROL_DMA_ROUND_ROBIN_EN
  logic prio;

  // prio names the channel that wins a tie; it moves to the other channel after each service
  always_comb begin
    pick = (req_0 && req_1) ? prio : !req_0;
  end
`else
  always_comb begin
    pick = !req_0;
  end
`endif

  always_comb begin
    sel_src = pick ? src_1 : src_0;
    sel_dst = pick ? dst_1 : dst_0;
    sel_len = pick ? len_1 : len_0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_w      <= '0;
      dst_w      <= '0;
      cnt        <= '0;
      ch         <= 1'b0;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      Estado_in  <= 1'b0;
      Estado_out <= 1'b0;
      busy       <= 1'b0;
`ifdef CONTROL_DMA_ROUND_ROBIN_EN
      prio       <= 1'b0;
`endif
    end else begin
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      Estado_in  <= 1'b0;
      Estado_out <= 1'b0;
      case (state)
        IDLE: begin
          if (req_0 || req_1) begin
            ch    <= pick;
            src_w <= sel_src;
            dst_w <= sel_dst;
            cnt   <= sel_len;
            gnt_0 <= !pick;
            gnt_1 <= pick;
            busy  <= 1'b1;
            if (sel_len == '0) begin
              state  <= DONE;
              done_0 <= !pick;
              done_1 <= pick;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= sel_src;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            mem_rd    <= 1'b0;
            Estado_in <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          Estado_out <= 1'b1;
          state      <= XFER;
        end
        XFER: begin
          mem_wr   <= 1'b1;
          mem_addr <= dst_w;
          state    <= WRITE;
        end
        WRITE: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            src_w  <= src_w + AW'(1);
            dst_w  <= dst_w + AW'(1);
            // cnt is never zero here; the <= guard keeps it from wrapping regardless
            if (cnt <= LW'(1)) begin
              cnt    <= '0;
              state  <= DONE;
              done_0 <= !ch;
              done_1 <= ch;
            end else begin
              cnt      <= cnt - LW'(1);
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= src_w + AW'(1);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef CONTROL_DMA_ROUND_ROBIN_EN
          prio  <= !ch;
`endif
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
